// File: rtl/mem_bus_if.sv
// rtl/mem_bus_if.sv - system-bus memory access sequencer behind P-A
// Captures address/data, runs a 4-phase request/answer handshake, returns a latched read word.
module mem_bus_if #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned RETRIES = 3
) (
  input  logic        __clk,
  input  logic        rst_,
  input  logic        rd,
  input  logic        wr,
  input  logic [0:15] dad,
  input  logic [0:15] ddt,
  input  logic [3:0]  nb,
  input  logic        bus_ok,
  input  logic        bus_en,
  input  logic        bus_pe,
  input  logic [0:15] bus_din,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [0:19] bus_ad,
  output logic [0:15] bus_dout,
  output logic [0:15] rdt,
  output logic        busy,
  output logic        done,
  output logic        pe,
  output logic        alarm
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BACKOFF,
    S_RELEASE,
    S_DONE
  } state_t;

  localparam logic [11:0] TMO_LAST  = 12'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(RETRIES);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        dir_wr_q, dir_wr_d;
  logic [0:15] addr_q, addr_d;
  logic [0:15] wdata_q, wdata_d;
  logic [3:0]  nb_q, nb_d;
  logic [0:15] rdt_q, rdt_d;
  logic        pe_q, pe_d;
  logic        alarm_q, alarm_d;

  always_ff @(posedge __clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      dir_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      nb_q     <= '0;
      rdt_q    <= '0;
      pe_q     <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      dir_wr_q <= dir_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      nb_q     <= nb_d;
      rdt_q    <= rdt_d;
      pe_q     <= pe_d;
      alarm_q  <= alarm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    dir_wr_d = dir_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    nb_d     = nb_q;
    rdt_d    = rdt_q;
    pe_d     = pe_q;
    alarm_d  = alarm_q;

    unique case (state_q)
      S_IDLE: begin
        if (rd || wr) begin
          addr_d   = dad;
          wdata_d  = ddt;
          nb_d     = nb;
          dir_wr_d = !rd;  // rd wins when both are raised
          pe_d     = 1'b0;
          alarm_d  = 1'b0;
          cnt_d    = '0;
          retry_d  = '0;
          state_d  = S_REQ;
        end
      end

      S_REQ: begin
        if (bus_ok) begin
          if (!dir_wr_q) rdt_d = bus_din;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (bus_pe && !dir_wr_q) begin
          pe_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (bus_en) begin
          if (retry_q == RETRY_MAX) begin
            alarm_d = 1'b1;
            cnt_d   = '0;
            state_d = S_RELEASE;
          end else begin
            state_d = S_BACKOFF;
          end
        end else if (cnt_q == TMO_LAST) begin
          alarm_d = 1'b1;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end

      S_BACKOFF: begin
        retry_d = retry_q + 4'd1;
        cnt_d   = '0;
        state_d = S_REQ;
      end

      S_RELEASE: begin
        if (!(bus_ok || bus_en || bus_pe)) begin
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          alarm_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from state so an async reset drops them in the same cycle.
  logic req_active;
  assign req_active = (state_q == S_REQ);

  assign bus_rd   = req_active && !dir_wr_q;
  assign bus_wr   = req_active && dir_wr_q;
  assign bus_ad   = req_active ? {nb_q, addr_q} : '0;
  assign bus_dout = bus_wr ? wdata_q : '0;
  assign rdt      = rdt_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign pe       = pe_q;
  assign alarm    = alarm_q;

endmodule
